riscv_lsu_outstanding: RTL and testbench



---
 rtl/riscv_lsu_pkg.sv | 49 ++++
 rtl/riscv_lsu_outstanding_if.sv | 23 ++
 rtl/riscv_lsu_meta_fifo.sv | 54 +++++
 rtl/riscv_lsu_outstanding.sv | 170 +++++++++++++++++
 tb/tb_riscv_lsu_outstanding.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_lsu_pkg.sv
// Shared types and helpers for the outstanding-capable load-store unit.
package riscv_lsu_pkg;

    // data_type encodings: 2'b1? is byte
    localparam logic [1:0] TYPE_WORD = 2'b00;
    localparam logic [1:0] TYPE_HALF = 2'b01;

    typedef enum logic [1:0] {
        PART_REGULAR = 2'd0,
        PART_FIRST   = 2'd1,
        PART_SECOND  = 2'd2
    } lsu_part_e;

    // Everything needed to turn a raw response back into a WB result
    typedef struct packed {
        logic [3:0] be;
        logic [1:0] shamt;
        logic [1:0] dtype;
        logic [1:0] sign_ext;
        logic       we;
        lsu_part_e  part;
    } lsu_meta_t;

    function automatic logic [3:0] base_be(input logic [1:0] dtype);
        if (dtype[1])      return 4'b0001;
        else if (dtype[0]) return 4'b0011;
        else               return 4'b1111;
    endfunction

    function automatic logic [31:0] be_to_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    // sign_ext: 00 zero fill, 10 ones fill, otherwise replicate the MSB
    function automatic logic [31:0] extend(input logic [31:0] value,
                                           input logic [1:0]  dtype,
                                           input logic [1:0]  sign_ext);
        logic        fill;
        logic [31:0] res;
        if (sign_ext == 2'b00)      fill = 1'b0;
        else if (sign_ext == 2'b10) fill = 1'b1;
        else                        fill = dtype[1] ? value[7] : value[15];
        if (dtype[1])      res = {{24{fill}}, value[7:0]};
        else if (dtype[0]) res = {{16{fill}}, value[15:0]};
        else               res = value;
        return res;
    endfunction

endpackage

// File: rtl/riscv_lsu_outstanding_if.sv
// OBI-style data memory port between the LSU (master) and memory (slave).
interface riscv_lsu_outstanding_if;
    logic        req;
    logic        gnt;
    logic        rvalid;
    logic        err;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [5:0]  atop;
    logic [31:0] rdata;

    modport master (
        output req, addr, we, be, wdata, atop,
        input  gnt, rvalid, err, rdata
    );

    modport slave (
        input  req, addr, we, be, wdata, atop,
        output gnt, rvalid, err, rdata
    );
endinterface

// File: rtl/riscv_lsu_meta_fifo.sv
// In-order metadata queue for granted requests; head is visible combinationally.
module riscv_lsu_meta_fifo
    import riscv_lsu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic                         pop,
    input  lsu_meta_t                    push_data,
    output lsu_meta_t                    head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    lsu_meta_t        storage [DEPTH];
    logic [PTR_W-1:0] rptr;
    logic [PTR_W-1:0] wptr;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Entry storage needs no reset; validity is tracked by count
    always_ff @(posedge clk_i) begin
        if (push) storage[wptr] <= push_data;
    end

    // Pointers and occupancy; a push into a full queue is legal only with a pop
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= ptr_next(wptr);
            if (pop)  rptr <= ptr_next(rptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head  = storage[rptr];
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/riscv_lsu_outstanding.sv
// Load-store unit with up to NUM_OUTSTANDING granted requests in flight.
// Optional stack-bounds check enabled by defining RISCV_LSU_STACK_CHECK_EN.
module riscv_lsu_outstanding
    import riscv_lsu_pkg::*;
#(
    parameter int NUM_OUTSTANDING = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    riscv_lsu_outstanding_if.master data_bus,

    input  logic        data_req_ex_i,
    input  logic        data_we_ex_i,
    input  logic [1:0]  data_type_ex_i,
    input  logic [1:0]  data_sign_ext_ex_i,
    input  logic [31:0] data_wdata_ex_i,
    input  logic [5:0]  data_atop_ex_i,
    input  logic [31:0] operand_a_ex_i,
    input  logic [31:0] operand_b_ex_i,
    input  logic        addr_useincr_ex_i,
    input  logic        data_misaligned_ex_i,
    output logic        data_misaligned_o,
    output logic        lsu_ready_ex_o,

    output logic        data_rvalid_o,
    output logic [31:0] data_rdata_o,
    output logic        data_err_o,
    output logic        data_we_wb_o,

    input  logic        stack_access_i,
    input  logic [31:0] stack_base_i,
    input  logic [31:0] stack_limit_i,
    output logic        stack_fault_o,

    output logic        busy_o
);
    localparam int CNT_W = $clog2(NUM_OUTSTANDING + 1);

    logic [31:0] addr_sum;
    logic [1:0]  shamt;
    logic [31:0] data_addr;
    logic [7:0]  wide_be;
    logic [63:0] wdata_dbl;
    logic        split_needed;
    logic        misaligned;
    logic        stack_fault;
    logic        data_req;
    logic        push;
    logic        pop;
    lsu_meta_t   push_meta;
    lsu_meta_t   head;
    logic        fifo_full;
    logic        fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    logic [31:0] rdata_masked;
    logic [31:0] rdata_aligned;
    logic [31:0] rdata_joined;
    logic [31:0] partial;
    logic        err_latch;

    // ---------------- request side ----------------
    assign addr_sum  = operand_a_ex_i + (addr_useincr_ex_i ? operand_b_ex_i : 32'd0);
    assign shamt     = addr_sum[1:0];
    // Second half of a split goes to the word boundary but keeps the original offset
    assign data_addr = data_misaligned_ex_i ? {addr_sum[31:2], 2'b00} : addr_sum;
    assign wide_be   = {4'b0000, base_be(data_type_ex_i)} << shamt;
    assign wdata_dbl = {data_wdata_ex_i, data_wdata_ex_i} << {shamt, 3'b000};

    assign split_needed = ((data_type_ex_i == TYPE_WORD) && (shamt != 2'd0)) ||
                          ((data_type_ex_i == TYPE_HALF) && (shamt == 2'd3));
    assign misaligned   = data_req_ex_i & ~data_misaligned_ex_i & split_needed;

`ifdef RISCV_LSU_STACK_CHECK_EN
    // Legal stack window is (limit, base]
    assign stack_fault = rst_ni & data_req_ex_i & stack_access_i &
                         ~((data_addr > stack_limit_i) && (data_addr <= stack_base_i));
`else
    logic unused_stack;
    assign unused_stack = ^{stack_access_i, stack_base_i, stack_limit_i};
    assign stack_fault  = 1'b0;
`endif

    // A same-cycle response frees a slot, so a full queue can still issue
    assign data_req = rst_ni & data_req_ex_i & ~stack_fault & (~fifo_full | data_bus.rvalid);
    assign push     = data_req & data_bus.gnt;
    assign pop      = rst_ni & data_bus.rvalid & ~fifo_empty;

    assign push_meta.be       = data_misaligned_ex_i ? wide_be[7:4] : wide_be[3:0];
    assign push_meta.shamt    = shamt;
    assign push_meta.dtype    = data_type_ex_i;
    assign push_meta.sign_ext = data_sign_ext_ex_i;
    assign push_meta.we       = data_we_ex_i;
    assign push_meta.part     = data_misaligned_ex_i ? PART_SECOND :
                                misaligned           ? PART_FIRST  : PART_REGULAR;

    riscv_lsu_meta_fifo #(
        .DEPTH (NUM_OUTSTANDING)
    ) u_meta_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (push),
        .pop       (pop),
        .push_data (push_meta),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign data_bus.req   = data_req;
    assign data_bus.addr  = data_addr;
    assign data_bus.we    = data_we_ex_i;
    assign data_bus.be    = push_meta.be;
    assign data_bus.wdata = wdata_dbl[63:32];
    assign data_bus.atop  = data_atop_ex_i;

    assign data_misaligned_o = misaligned;
    assign lsu_ready_ex_o    = ~rst_ni | ~data_req_ex_i | push | stack_fault;
    assign stack_fault_o     = stack_fault;
    assign busy_o            = rst_ni & ((fifo_count != '0) | data_req);

    // ---------------- response side ----------------
    assign rdata_masked  = data_bus.rdata & be_to_mask(head.be);
    assign rdata_aligned = rdata_masked >> {head.shamt, 3'b000};
    // Upper bytes of a split come from the second word's low lanes
    assign rdata_joined  = (rdata_masked << (6'd32 - {1'b0, head.shamt, 3'b000})) | partial;

    // Build the WB result for the final part of each access
    always_comb begin
        data_rvalid_o = 1'b0;
        data_rdata_o  = 32'd0;
        data_err_o    = 1'b0;
        data_we_wb_o  = 1'b0;
        if (pop) begin
            case (head.part)
                PART_REGULAR: begin
                    data_rvalid_o = 1'b1;
                    data_err_o    = data_bus.err;
                    data_we_wb_o  = head.we;
                    data_rdata_o  = head.we ? 32'd0 :
                                    extend(rdata_aligned, head.dtype, head.sign_ext);
                end
                PART_SECOND: begin
                    data_rvalid_o = 1'b1;
                    data_err_o    = err_latch | data_bus.err;
                    data_we_wb_o  = head.we;
                    data_rdata_o  = head.we ? 32'd0 :
                                    extend(rdata_joined, head.dtype, head.sign_ext);
                end
                default: ;
            endcase
        end
    end

    // Hold the low bytes and error of a split until its second response
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            partial   <= 32'd0;
            err_latch <= 1'b0;
        end else if (pop && (head.part == PART_FIRST)) begin
            partial   <= rdata_aligned;
            err_latch <= data_bus.err;
        end
    end

    // A response with nothing in flight means the memory side is out of sync
    assert property (@(posedge clk_i) disable iff (!rst_ni) data_bus.rvalid |-> !fifo_empty);

endmodule

// File: tb/tb_riscv_lsu_outstanding.sv
module tb_riscv_lsu_outstanding;
    localparam int NUM = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        data_req_ex, data_we_ex, addr_useincr, data_misaligned_ex;
    logic [1:0]  data_type_ex, data_sign_ext_ex;
    logic [31:0] data_wdata_ex, operand_a, operand_b;
    logic [5:0]  data_atop_ex;
    logic        data_misaligned, lsu_ready_ex, data_rvalid, data_err, data_we_wb;
    logic [31:0] data_rdata;
    logic        stack_access;
    logic [31:0] stack_base, stack_limit;
    logic        stack_fault, busy;

    int tests = 0;
    int fails = 0;

    riscv_lsu_outstanding_if bus ();

    riscv_lsu_outstanding #(.NUM_OUTSTANDING(NUM)) dut (
        .clk_i                (clk),
        .rst_ni               (rst_n),
        .data_bus             (bus),
        .data_req_ex_i        (data_req_ex),
        .data_we_ex_i         (data_we_ex),
        .data_type_ex_i       (data_type_ex),
        .data_sign_ext_ex_i   (data_sign_ext_ex),
        .data_wdata_ex_i      (data_wdata_ex),
        .data_atop_ex_i       (data_atop_ex),
        .operand_a_ex_i       (operand_a),
        .operand_b_ex_i       (operand_b),
        .addr_useincr_ex_i    (addr_useincr),
        .data_misaligned_ex_i (data_misaligned_ex),
        .data_misaligned_o    (data_misaligned),
        .lsu_ready_ex_o       (lsu_ready_ex),
        .data_rvalid_o        (data_rvalid),
        .data_rdata_o         (data_rdata),
        .data_err_o           (data_err),
        .data_we_wb_o         (data_we_wb),
        .stack_access_i       (stack_access),
        .stack_base_i         (stack_base),
        .stack_limit_i        (stack_limit),
        .stack_fault_o        (stack_fault),
        .busy_o               (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic ex_set(input logic we, input logic [1:0] dtype, input logic [1:0] sext,
                          input logic [31:0] a, input logic [31:0] wd, input logic mis);
        data_req_ex = 1'b1; data_we_ex = we; data_type_ex = dtype; data_sign_ext_ex = sext;
        operand_a = a; operand_b = 32'hFFFF_FFF0; addr_useincr = 1'b0;
        data_wdata_ex = wd; data_misaligned_ex = mis;
    endtask

    task automatic ex_idle();
        data_req_ex = 1'b0; data_misaligned_ex = 1'b0;
    endtask

    task automatic mem_set(input logic g, input logic rv, input logic [31:0] rd, input logic e);
        bus.gnt = g; bus.rvalid = rv; bus.rdata = rd; bus.err = e;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] addr;
        logic [1:0]  dtype;
        logic [1:0]  sext;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] result;
        int          size;
        int          nacc;
    } op_t;

    typedef struct {
        logic [31:0] rdata;
        logic        last;
        logic        second;
        logic        we;
        logic [31:0] result;
    } pend_t;

    logic [7:0]  rmem [logic [31:0]];
    logic [31:0] smem [logic [31:0]];
    pend_t       pend [$];

    function automatic int size_of(input logic [1:0] t);
        return t[1] ? 1 : (t[0] ? 2 : 4);
    endfunction

    function automatic logic [7:0] init_byte(input logic [31:0] a);
        logic [31:0] v;
        v = a * 32'd37 + 32'd11;
        return v[7:0];
    endfunction

    function automatic logic [7:0] ref_rd(input logic [31:0] a);
        if (rmem.exists(a)) return rmem[a];
        return init_byte(a);
    endfunction

    function automatic logic [31:0] slave_rd(input logic [31:0] wa);
        if (smem.exists(wa)) return smem[wa];
        return {init_byte(wa + 3), init_byte(wa + 2), init_byte(wa + 1), init_byte(wa)};
    endfunction

    op_t         cur;
    pend_t       p, h;
    logic        have_op, exp_req, exp_rv, fill, err_acc;
    logic [31:0] target, wb, lm, ewd, ba, w, dm;
    logic [3:0]  ebe;
    int          acc, ops_left, cyc, off;

    initial begin
        rst_n = 1'b0;
        ex_set(1'b0, 2'b00, 2'b00, 32'h100, 32'h0, 1'b0);
        data_atop_ex = 6'h15;
        mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        stack_access = 1'b0; stack_base = 32'h0; stack_limit = 32'h0;
        @(negedge clk);
        chk1("rst_req", bus.req, 1'b0);
        chk1("rst_ready", lsu_ready_ex, 1'b1);
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_rvalid", data_rvalid, 1'b0);
        chk1("rst_fault", stack_fault, 1'b0);
        step();
        rst_n = 1'b1;

        // LW 0x100, gnt same cycle, response next cycle
        ex_set(1'b0, 2'b00, 2'b00, 32'h100, 32'h0, 1'b0);
        mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("lw_req", bus.req, 1'b1);
        chk("lw_addr", bus.addr, 32'h100);
        chk("lw_be", {28'd0, bus.be}, 32'hF);
        chk("lw_atop", {26'd0, bus.atop}, 32'h15);
        chk1("lw_ready", lsu_ready_ex, 1'b1);
        chk1("lw_rv_early", data_rvalid, 1'b0);
        step();
        ex_idle(); mem_set(1'b0, 1'b1, 32'hDEADBEEF, 1'b0);
        #1;
        chk1("lw_rvalid", data_rvalid, 1'b1);
        chk("lw_rdata", data_rdata, 32'hDEADBEEF);
        chk1("lw_wewb", data_we_wb, 1'b0);
        chk1("lw_busy", busy, 1'b1);
        step();
        mem_set(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("lw_idle_busy", busy, 1'b0);

        // Three back-to-back loads against a two-deep queue
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h200, 32'h0, 1'b0); mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        #1; chk1("b2b_req0", bus.req, 1'b1);
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h204, 32'h0, 1'b0);
        #1; chk1("b2b_req1", bus.req, 1'b1);
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h208, 32'h0, 1'b0);
        #1; chk1("b2b_req2_stall", bus.req, 1'b0); chk1("b2b_ready_stall", lsu_ready_ex, 1'b0);
        step();
        #1; chk1("b2b_req2_hold", bus.req, 1'b0);
        step();
        mem_set(1'b1, 1'b1, 32'h11111111, 1'b0);
        #1;
        chk1("b2b_req2_issue", bus.req, 1'b1);
        chk1("b2b_ready_issue", lsu_ready_ex, 1'b1);
        chk("b2b_rdata0", data_rdata, 32'h11111111);
        step();
        ex_idle(); mem_set(1'b0, 1'b1, 32'h22222222, 1'b0);
        #1; chk("b2b_rdata1", data_rdata, 32'h22222222);
        step();
        mem_set(1'b0, 1'b1, 32'h33333333, 1'b0);
        #1; chk("b2b_rdata2", data_rdata, 32'h33333333); chk1("b2b_rv2", data_rvalid, 1'b1);
        step();
        mem_set(1'b0, 1'b0, 32'h0, 1'b0);
        #1; chk1("b2b_drained", busy, 1'b0);

        // Misaligned LW at 0x102
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h102, 32'h0, 1'b0); mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("mlw_misal", data_misaligned, 1'b1);
        chk("mlw_be0", {28'd0, bus.be}, 32'hC);
        chk("mlw_addr0", bus.addr, 32'h102);
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h106, 32'h0, 1'b1); mem_set(1'b1, 1'b1, 32'h1122ABCD, 1'b0);
        #1;
        chk("mlw_addr1", bus.addr, 32'h104);
        chk("mlw_be1", {28'd0, bus.be}, 32'h3);
        chk1("mlw_misal1", data_misaligned, 1'b0);
        chk1("mlw_rv_first", data_rvalid, 1'b0);
        step();
        ex_idle(); mem_set(1'b0, 1'b1, 32'hEEEE3344, 1'b0);
        #1;
        chk1("mlw_rv", data_rvalid, 1'b1);
        chk("mlw_rdata", data_rdata, 32'h33441122);

        // Signed LH at 0x103
        step();
        ex_set(1'b0, 2'b01, 2'b01, 32'h103, 32'h0, 1'b0); mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk1("mlh_misal", data_misaligned, 1'b1);
        chk("mlh_be0", {28'd0, bus.be}, 32'h8);
        step();
        ex_set(1'b0, 2'b01, 2'b01, 32'h107, 32'h0, 1'b1); mem_set(1'b1, 1'b1, 32'h80123456, 1'b0);
        #1;
        chk("mlh_be1", {28'd0, bus.be}, 32'h1);
        step();
        ex_idle(); mem_set(1'b0, 1'b1, 32'h123456FF, 1'b0);
        #1;
        chk("mlh_rdata", data_rdata, 32'hFFFFFF80);

        // Error on the first half surfaces only with the second
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h101, 32'h0, 1'b0); mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h105, 32'h0, 1'b1); mem_set(1'b1, 1'b1, 32'hAABBCCDD, 1'b1);
        #1;
        chk1("merr_rv_first", data_rvalid, 1'b0);
        chk1("merr_err_first", data_err, 1'b0);
        step();
        ex_idle(); mem_set(1'b0, 1'b1, 32'h12345678, 1'b0);
        #1;
        chk1("merr_rv", data_rvalid, 1'b1);
        chk1("merr_err", data_err, 1'b1);
        chk("merr_rdata", data_rdata, 32'h78AABBCC);

        // SB at 0x301
        step();
        ex_set(1'b1, 2'b10, 2'b00, 32'h301, 32'h000000A5, 1'b0); mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        #1;
        chk("sb_be", {28'd0, bus.be}, 32'h2);
        chk("sb_wdata", bus.wdata, 32'h0000A500);
        chk1("sb_we", bus.we, 1'b1);
        step();
        ex_idle(); mem_set(1'b0, 1'b1, 32'hCAFEF00D, 1'b0);
        #1;
        chk1("sb_rv", data_rvalid, 1'b1);
        chk1("sb_wewb", data_we_wb, 1'b1);
        chk("sb_rdata", data_rdata, 32'h0);

        // Reset with two requests in flight
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h400, 32'h0, 1'b0); mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h404, 32'h0, 1'b0);
        step();
        rst_n = 1'b0; mem_set(1'b1, 1'b1, 32'h99999999, 1'b0);
        #1;
        chk1("mrst_req", bus.req, 1'b0);
        chk1("mrst_ready", lsu_ready_ex, 1'b1);
        chk1("mrst_busy", busy, 1'b0);
        chk1("mrst_rvalid", data_rvalid, 1'b0);
        step();
        rst_n = 1'b1; ex_idle(); mem_set(1'b0, 1'b0, 32'h0, 1'b0);
        #1; chk1("mrst_cleared", busy, 1'b0);
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h500, 32'h0, 1'b0); mem_set(1'b1, 1'b0, 32'h0, 1'b0);
        #1; chk1("mrst_req_after", bus.req, 1'b1);
        step();
        ex_idle(); mem_set(1'b0, 1'b1, 32'h5555AAAA, 1'b0);
        #1; chk("mrst_rdata_after", data_rdata, 32'h5555AAAA);
        step();
        mem_set(1'b0, 1'b0, 32'h0, 1'b0);

        // Stack bounds
        stack_access = 1'b1; stack_limit = 32'h1000; stack_base = 32'h1FFC;
        ex_set(1'b0, 2'b00, 2'b00, 32'h2000, 32'h0, 1'b0); mem_set(1'b0, 1'b0, 32'h0, 1'b0);
        #1;
`ifdef RISCV_LSU_STACK_CHECK_EN
        chk1("stk_fault", stack_fault, 1'b1);
        chk1("stk_req", bus.req, 1'b0);
        chk1("stk_ready", lsu_ready_ex, 1'b1);
        step();
        ex_set(1'b0, 2'b00, 2'b00, 32'h1800, 32'h0, 1'b0);
        #1;
        chk1("stk_ok_fault", stack_fault, 1'b0);
        chk1("stk_ok_req", bus.req, 1'b1);
`else
        chk1("stk_off_fault", stack_fault, 1'b0);
        chk1("stk_off_req", bus.req, 1'b1);
`endif
        step();
        stack_access = 1'b0; ex_idle();

        // Randomized traffic against the byte-level reference model
        ops_left = 400; have_op = 1'b0; cyc = 0; acc = 0; err_acc = 1'b0;
        wb = 32'd0; lm = 32'd0;
        while ((ops_left > 0 || have_op || pend.size() > 0) && cyc < 20000) begin
            cyc++;
            if (!have_op && ops_left > 0 && $urandom_range(0, 3) != 0) begin
                cur.addr  = 32'h1000 + 32'($urandom_range(0, 31));
                cur.dtype = 2'($urandom_range(0, 3));
                cur.sext  = 2'($urandom_range(0, 3));
                cur.we    = 1'($urandom_range(0, 1));
                cur.wdata = $urandom;
                cur.size  = size_of(cur.dtype);
                cur.nacc  = (int'(cur.addr[1:0]) + cur.size > 4) ? 2 : 1;
                cur.result = 32'd0;
                for (int j = 0; j < cur.size; j++) begin
                    if (cur.we) rmem[cur.addr + 32'(j)] = cur.wdata[8*j +: 8];
                    else        cur.result[8*j +: 8] = ref_rd(cur.addr + 32'(j));
                end
                if (!cur.we && cur.size < 4) begin
                    if (cur.sext == 2'b00)      fill = 1'b0;
                    else if (cur.sext == 2'b10) fill = 1'b1;
                    else                        fill = cur.result[8*cur.size-1];
                    for (int j = 8*cur.size; j < 32; j++) cur.result[j] = fill;
                end
                have_op = 1'b1; acc = 0; ops_left--;
            end

            if (have_op) begin
                target = (acc == 0) ? cur.addr : cur.addr + 32'd4;
                data_req_ex = 1'b1; data_we_ex = cur.we; data_type_ex = cur.dtype;
                data_sign_ext_ex = cur.sext; data_wdata_ex = cur.wdata;
                data_misaligned_ex = (acc == 1);
                addr_useincr = 1'($urandom_range(0, 1));
                operand_b = $urandom;
                operand_a = addr_useincr ? target - operand_b : target;
            end else begin
                data_req_ex = 1'b0; data_misaligned_ex = 1'b0; operand_a = $urandom;
            end
            bus.gnt    = ($urandom_range(0, 3) != 0);
            bus.rvalid = (pend.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.rdata  = bus.rvalid ? pend[0].rdata : $urandom;
            bus.err    = bus.rvalid && ($urandom_range(0, 7) == 0);
            #1;

            exp_req = have_op && (pend.size() < NUM || bus.rvalid);
            chk1("rnd_req", bus.req, exp_req);
            if (exp_req) begin
                wb = {cur.addr[31:2], 2'b00} + ((acc == 1) ? 32'd4 : 32'd0);
                lm = 32'd0; ebe = 4'd0; ewd = 32'd0;
                for (int i = 0; i < 4; i++) begin
                    ba = wb + 32'(i);
                    if (ba >= cur.addr && ba < cur.addr + 32'(cur.size)) begin
                        off = int'(ba - cur.addr);
                        ebe[i] = 1'b1;
                        lm[8*i +: 8] = 8'hFF;
                        ewd[8*i +: 8] = cur.wdata[8*off +: 8];
                    end
                end
                chk("rnd_addr", bus.addr, (acc == 0) ? cur.addr : wb);
                chk("rnd_be", {28'd0, bus.be}, {28'd0, ebe});
                chk1("rnd_we", bus.we, cur.we);
                chk1("rnd_misal", data_misaligned, (acc == 0) && (cur.nacc == 2));
                if (cur.we) chk("rnd_wdata", bus.wdata & lm, ewd);
            end
            chk1("rnd_ready", lsu_ready_ex, !have_op || (exp_req && bus.gnt));
            exp_rv = bus.rvalid && (pend.size() > 0) && pend[0].last;
            chk1("rnd_rvalid", data_rvalid, exp_rv);
            if (exp_rv) begin
                chk("rnd_rdata", data_rdata, pend[0].we ? 32'd0 : pend[0].result);
                chk1("rnd_err", data_err, bus.err | (pend[0].second & err_acc));
                chk1("rnd_wewb", data_we_wb, pend[0].we);
            end
            chk1("rnd_busy", busy, (pend.size() != 0) || exp_req);

            if (bus.rvalid) begin
                h = pend.pop_front();
                if (!h.last) err_acc = bus.err;
            end
            if (exp_req && bus.gnt) begin
                w = slave_rd(wb);
                if (cur.we) begin
                    for (int i = 0; i < 4; i++) dm[8*i +: 8] = {8{bus.be[i]}};
                    smem[wb] = (w & ~dm) | (bus.wdata & dm);
                    p.rdata = $urandom;
                end else begin
                    p.rdata = (w & lm) | ($urandom & ~lm);
                end
                p.last   = (acc == cur.nacc - 1);
                p.second = (acc == 1);
                p.we     = cur.we;
                p.result = cur.result;
                pend.push_back(p);
                acc++;
                if (acc == cur.nacc) have_op = 1'b0;
            end
            @(negedge clk);
        end
        chk("rnd_completed", 32'(pend.size() + ops_left), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
